// File: rtl/pie_decoder.sv
// PIE downlink decoder: measures delimiter, data-0, RTcal and optional TRcal,
// then slices data symbols against pivot = RTcal/2 into a bit stream.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for the falling edge that opens a delimiter
// S_DELIM | delimiter low in progress, length checked on the rising edge
// S_DATA0 | measuring data-0 (Tari), rising edge to rising edge
// S_RTCAL | measuring RTcal, checked against 2..3.5 Tari
// S_CAL2  | next symbol is either TRcal (longer than RTcal) or the first bit
// S_DATA  | slicing data symbols; no edge within RTcal ends the frame
module pie_decoder #(
  parameter int CNT_W     = 10,
  parameter int DELIM_MIN = 20,
  parameter int DELIM_MAX = 29,
  parameter int TARI_MIN  = 11,
  parameter int TARI_MAX  = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx_env,
  input  logic             i_rx_en,
  input  logic             i_clear_cu,
  output logic             o_bit_valid_pie,
  output logic             o_bit_data_pie,
  output logic             o_frame_start_pie,
  output logic             o_frame_end_pie,
  output logic             o_err_pie,
  output logic [7:0]       o_bit_cnt_pie,
  output logic [CNT_W-1:0] o_tari_pie,
  output logic [CNT_W-1:0] o_rtcal_pie,
  output logic [CNT_W-1:0] o_trcal_pie,
  output logic             o_trcal_valid_pie
);

  // Two extra bits so 3.5*Tari and cnt+1 never wrap.
  localparam int LW = CNT_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_DELIM, S_DATA0, S_RTCAL, S_CAL2, S_DATA} state_t;

  state_t state, state_nxt;

  logic             rx_s1, rx_s2, rx_s3;
  logic             rise, fall, abort;
  logic [CNT_W-1:0] cnt, len_sat;
  logic [CNT_W-1:0] tari_q, rtcal_q, trcal_q, pivot_q;
  logic [7:0]       bit_cnt_q;
  logic             trcal_valid_q, bit_data_q;
  logic             bit_valid_q, start_q, end_q, err_q;
  logic             cnt_max;
  logic [LW-1:0]    len, tari_x, rtcal_x, lo_lim, hi_lim;
  logic             delim_ok, tari_ok, rtcal_ok, is_trcal, delim_to, data_to, bit_val;

  logic ev_err, ev_start, ev_bit, ev_end, ev_tari, ev_trcal, cnt_clr;

  assign abort    = i_clear_cu | ~i_rx_en;
  assign rise     = rx_s2 & ~rx_s3;
  assign fall     = ~rx_s2 & rx_s3;
  assign cnt_max  = &cnt;
  assign len      = LW'(cnt) + LW'(1);
  assign len_sat  = cnt_max ? cnt : cnt + CNT_W'(1);
  assign tari_x   = LW'(tari_q);
  assign rtcal_x  = LW'(rtcal_q);
  assign lo_lim   = tari_x << 1;
  assign hi_lim   = (tari_x << 1) + tari_x + (tari_x >> 1);
  assign delim_ok = (len >= LW'(DELIM_MIN)) && (len <= LW'(DELIM_MAX));
  assign delim_to = (len == LW'(DELIM_MAX + 1));
  assign tari_ok  = (len >= LW'(TARI_MIN)) && (len <= LW'(TARI_MAX));
  assign rtcal_ok = (len > lo_lim) && (len <= hi_lim);
  assign is_trcal = (len > rtcal_x);
  assign data_to  = (len == rtcal_x);
  assign bit_val  = (len >= LW'(pivot_q));

  // State register; every abort source returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst || abort) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Next-state decode from edges and measured interval.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fall) state_nxt = S_DELIM;
      S_DELIM: if (rise) state_nxt = delim_ok ? S_DATA0 : S_IDLE;
               else if (delim_to) state_nxt = S_IDLE;
      S_DATA0: if (rise) state_nxt = tari_ok ? S_RTCAL : S_IDLE;
               else if (cnt_max) state_nxt = S_IDLE;
      S_RTCAL: if (rise) state_nxt = rtcal_ok ? S_CAL2 : S_IDLE;
               else if (cnt_max) state_nxt = S_IDLE;
      S_CAL2:  if (rise) state_nxt = S_DATA;
               else if (cnt_max) state_nxt = S_IDLE;
      S_DATA:  if (!rise && data_to) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-cycle events that the datapath registers into pulses and captures.
  always_comb begin
    ev_err   = 1'b0;
    ev_start = 1'b0;
    ev_bit   = 1'b0;
    ev_end   = 1'b0;
    ev_tari  = 1'b0;
    ev_trcal = 1'b0;
    cnt_clr  = 1'b0;
    case (state)
      S_IDLE:  cnt_clr = fall;
      S_DELIM: begin
        if (rise) begin
          cnt_clr = 1'b1;
          ev_err  = ~delim_ok;
        end else if (delim_to) ev_err = 1'b1;
      end
      S_DATA0: begin
        if (rise) begin
          cnt_clr = 1'b1;
          ev_tari = tari_ok;
          ev_err  = ~tari_ok;
        end else if (cnt_max) ev_err = 1'b1;
      end
      S_RTCAL: begin
        if (rise) begin
          cnt_clr  = 1'b1;
          ev_start = rtcal_ok;
          ev_err   = ~rtcal_ok;
        end else if (cnt_max) ev_err = 1'b1;
      end
      S_CAL2: begin
        if (rise) begin
          cnt_clr  = 1'b1;
          ev_trcal = is_trcal;
          ev_bit   = ~is_trcal;
        end else if (cnt_max) ev_err = 1'b1;
      end
      S_DATA: begin
        if (rise) begin
          cnt_clr = 1'b1;
          ev_bit  = 1'b1;
        end else if (data_to) begin
          ev_end = rx_s2;
          ev_err = ~rx_s2;
        end
      end
      default: ev_err = 1'b0;
    endcase
  end

  // Synchronizer, interval counter, captured calibration values and pulses.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      rx_s1         <= 1'b0;
      rx_s2         <= 1'b0;
      rx_s3         <= 1'b0;
      cnt           <= '0;
      tari_q        <= '0;
      rtcal_q       <= '0;
      trcal_q       <= '0;
      pivot_q       <= '0;
      bit_cnt_q     <= '0;
      trcal_valid_q <= 1'b0;
      bit_data_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      start_q       <= 1'b0;
      end_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rx_s1       <= i_rx_env;
      rx_s2       <= rx_s1;
      rx_s3       <= rx_s2;
      cnt         <= cnt_clr ? '0 : len_sat;
      bit_valid_q <= ev_bit;
      start_q     <= ev_start;
      end_q       <= ev_end;
      err_q       <= ev_err;
      if (ev_tari) tari_q <= len_sat;
      if (ev_start) begin
        rtcal_q       <= len_sat;
        pivot_q       <= len_sat >> 1;
        bit_cnt_q     <= '0;
        trcal_valid_q <= 1'b0;
      end
      if (ev_trcal) begin
        trcal_q       <= len_sat;
        trcal_valid_q <= 1'b1;
      end
      if (ev_bit) begin
        bit_data_q <= bit_val;
        if (bit_cnt_q != 8'hFF) bit_cnt_q <= bit_cnt_q + 8'd1;
      end
    end
  end

  assign o_bit_valid_pie   = bit_valid_q;
  assign o_bit_data_pie    = bit_data_q;
  assign o_frame_start_pie = start_q;
  assign o_frame_end_pie   = end_q;
  assign o_err_pie         = err_q;
  assign o_bit_cnt_pie     = bit_cnt_q;
  assign o_tari_pie        = tari_q;
  assign o_rtcal_pie       = rtcal_q;
  assign o_trcal_pie       = trcal_q;
  assign o_trcal_valid_pie = trcal_valid_q;

endmodule

// File: tb/tb_pie_decoder.sv
// Directed bench for pie_decoder: drives PIE waveforms symbol by symbol and
// checks decoded bits, calibration captures, frame pulses and error paths.
module tb_pie_decoder;

  localparam int PW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_en = 1'b1;
  logic       clear_cu = 1'b0;
  logic       bit_valid, bit_data, frame_start, frame_end, err, trcal_valid;
  logic [7:0] bit_cnt;
  logic [9:0] tari, rtcal, trcal;

  int checks = 0;
  int failures = 0;

  int cyc = 0, n_fs = 0, n_fe = 0, n_err = 0, n_bits = 0;
  int fe_cyc = 0, last_bit_cyc = 0;
  logic bits [0:255];

  pie_decoder dut (
    .clk(clk), .rst(rst), .i_rx_env(rx), .i_rx_en(rx_en), .i_clear_cu(clear_cu),
    .o_bit_valid_pie(bit_valid), .o_bit_data_pie(bit_data),
    .o_frame_start_pie(frame_start), .o_frame_end_pie(frame_end), .o_err_pie(err),
    .o_bit_cnt_pie(bit_cnt), .o_tari_pie(tari), .o_rtcal_pie(rtcal),
    .o_trcal_pie(trcal), .o_trcal_valid_pie(trcal_valid)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bit_valid && n_bits < 256) begin
      bits[n_bits] <= bit_data;
      n_bits       <= n_bits + 1;
      last_bit_cyc <= cyc;
    end
    if (frame_start) n_fs <= n_fs + 1;
    if (frame_end) begin
      n_fe   <= n_fe + 1;
      fe_cyc <= cyc;
    end
    if (err) n_err <= n_err + 1;
  end

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // One PIE symbol of total length L, measured rising edge to rising edge.
  task automatic sym(input int len);
    line(1'b1, len - PW);
    line(1'b0, PW);
  endtask

  task automatic head(input int delim, input int t, input int rt, input int tr);
    line(1'b1, 20);
    line(1'b0, delim);
    sym(t);
    sym(rt);
    if (tr > 0) sym(tr);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL rst_bit_valid got=%0b exp=0", bit_valid); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start got=%0b exp=0", frame_start); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
    checks++; if (tari !== 10'd0) begin failures++; $display("FAIL rst_tari got=%0d exp=0", tari); end
    checks++; if (rtcal !== 10'd0) begin failures++; $display("FAIL rst_rtcal got=%0d exp=0", rtcal); end
    checks++; if (trcal_valid !== 1'b0) begin failures++; $display("FAIL rst_trcal_valid got=%0b exp=0", trcal_valid); end
    checks++; if (bit_cnt !== 8'd0) begin failures++; $display("FAIL rst_bit_cnt got=%0d exp=0", bit_cnt); end
    rst = 1'b0;
    line(1'b1, 10);
  endtask

  task automatic test_query;
    int fs0, fe0, e0, b0;
    logic ex [4];
    ex = '{1'b1, 1'b0, 1'b0, 1'b0};
    fs0 = n_fs; fe0 = n_fe; e0 = n_err; b0 = n_bits;
    head(24, 24, 66, 150);
    sym(40); sym(24); sym(24); sym(24);
    line(1'b1, 100);
    checks++; if (n_fs - fs0 != 1) begin failures++; $display("FAIL q_frame_start got=%0d exp=1", n_fs - fs0); end
    checks++; if (tari !== 10'd24) begin failures++; $display("FAIL q_tari got=%0d exp=24", tari); end
    checks++; if (rtcal !== 10'd66) begin failures++; $display("FAIL q_rtcal got=%0d exp=66", rtcal); end
    checks++; if (trcal !== 10'd150) begin failures++; $display("FAIL q_trcal got=%0d exp=150", trcal); end
    checks++; if (trcal_valid !== 1'b1) begin failures++; $display("FAIL q_trcal_valid got=%0b exp=1", trcal_valid); end
    checks++; if (n_bits - b0 != 4) begin failures++; $display("FAIL q_nbits got=%0d exp=4", n_bits - b0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bits[b0+i] !== ex[i]) begin failures++; $display("FAIL q_bit%0d got=%0b exp=%0b", i, bits[b0+i], ex[i]); end
    end
    checks++; if (n_fe - fe0 != 1) begin failures++; $display("FAIL q_frame_end got=%0d exp=1", n_fe - fe0); end
    checks++; if (fe_cyc - last_bit_cyc != 66) begin failures++; $display("FAIL q_end_delay got=%0d exp=66", fe_cyc - last_bit_cyc); end
    checks++; if (bit_cnt !== 8'd4) begin failures++; $display("FAIL q_bit_cnt got=%0d exp=4", bit_cnt); end
    checks++; if (n_err != e0) begin failures++; $display("FAIL q_err got=%0d exp=0", n_err - e0); end
  endtask

  task automatic test_non_query;
    int fe0, b0;
    fe0 = n_fe; b0 = n_bits;
    head(24, 24, 66, 0);
    sym(24); sym(40);
    line(1'b1, 100);
    checks++; if (trcal_valid !== 1'b0) begin failures++; $display("FAIL nq_trcal_valid got=%0b exp=0", trcal_valid); end
    checks++; if (n_bits - b0 != 2) begin failures++; $display("FAIL nq_nbits got=%0d exp=2", n_bits - b0); end
    checks++; if (bits[b0] !== 1'b0) begin failures++; $display("FAIL nq_bit0 got=%0b exp=0", bits[b0]); end
    checks++; if (bits[b0+1] !== 1'b1) begin failures++; $display("FAIL nq_bit1 got=%0b exp=1", bits[b0+1]); end
    checks++; if (bit_cnt !== 8'd2) begin failures++; $display("FAIL nq_bit_cnt got=%0d exp=2", bit_cnt); end
    checks++; if (n_fe - fe0 != 1) begin failures++; $display("FAIL nq_frame_end got=%0d exp=1", n_fe - fe0); end
  endtask

  task automatic test_pivot;
    int b0;
    b0 = n_bits;
    head(24, 24, 66, 150);
    sym(33); sym(32);
    line(1'b1, 100);
    checks++; if (n_bits - b0 != 2) begin failures++; $display("FAIL pv_nbits got=%0d exp=2", n_bits - b0); end
    checks++; if (bits[b0] !== 1'b1) begin failures++; $display("FAIL pv_len33 got=%0b exp=1", bits[b0]); end
    checks++; if (bits[b0+1] !== 1'b0) begin failures++; $display("FAIL pv_len32 got=%0b exp=0", bits[b0+1]); end
  endtask

  task automatic test_framing_err;
    int fs0, e0, k;
    fs0 = n_fs; e0 = n_err;
    line(1'b1, 20); line(1'b0, 15); line(1'b1, 100);
    checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL fe_short_delim got=%0d exp=1", n_err - e0); end
    e0 = n_err;
    line(1'b1, 20);
    rx = 1'b0;
    k = 0;
    for (int i = 1; i <= 60 && k == 0; i++) begin
      @(negedge clk);
      if (err) k = i;
    end
    checks++; if (k != 33) begin failures++; $display("FAIL fe_long_delim_cycle got=%0d exp=33", k); end
    line(1'b0, 5); line(1'b1, 100);
    checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL fe_long_delim got=%0d exp=1", n_err - e0); end
    e0 = n_err;
    head(24, 24, 40, 0);
    line(1'b1, 100);
    checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL fe_rtcal got=%0d exp=1", n_err - e0); end
    checks++; if (n_fs != fs0) begin failures++; $display("FAIL fe_frame_start got=%0d exp=0", n_fs - fs0); end
  endtask

  task automatic test_stuck_low;
    int fe0, e0, b0;
    logic ex [4];
    ex = '{1'b1, 1'b0, 1'b0, 1'b0};
    fe0 = n_fe; e0 = n_err; b0 = n_bits;
    head(24, 24, 66, 150);
    sym(40);
    line(1'b1, 10); line(1'b0, 80); line(1'b1, 100);
    checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL sl_err got=%0d exp=1", n_err - e0); end
    checks++; if (n_fe != fe0) begin failures++; $display("FAIL sl_frame_end got=%0d exp=0", n_fe - fe0); end
    checks++; if (n_bits - b0 != 1) begin failures++; $display("FAIL sl_nbits got=%0d exp=1", n_bits - b0); end
    fe0 = n_fe; b0 = n_bits;
    head(24, 24, 66, 150);
    sym(40); sym(24); sym(24); sym(24);
    line(1'b1, 100);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bits[b0+i] !== ex[i]) begin failures++; $display("FAIL sl_next_bit%0d got=%0b exp=%0b", i, bits[b0+i], ex[i]); end
    end
    checks++; if (n_fe - fe0 != 1) begin failures++; $display("FAIL sl_next_end got=%0d exp=1", n_fe - fe0); end
  endtask

  task automatic test_abort;
    int fe0, e0, b0;
    fe0 = n_fe; e0 = n_err;
    head(24, 24, 66, 150);
    sym(40); sym(24);
    line(1'b1, 10);
    checks++; if (bit_cnt !== 8'd2) begin failures++; $display("FAIL ab_bits_before got=%0d exp=2", bit_cnt); end
    clear_cu = 1'b1;
    line(1'b1, 2);
    checks++; if (bit_cnt !== 8'd0) begin failures++; $display("FAIL ab_clr_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (tari !== 10'd0) begin failures++; $display("FAIL ab_clr_tari got=%0d exp=0", tari); end
    checks++; if (rtcal !== 10'd0) begin failures++; $display("FAIL ab_clr_rtcal got=%0d exp=0", rtcal); end
    checks++; if (trcal !== 10'd0) begin failures++; $display("FAIL ab_clr_trcal got=%0d exp=0", trcal); end
    checks++; if (trcal_valid !== 1'b0) begin failures++; $display("FAIL ab_clr_trcal_valid got=%0b exp=0", trcal_valid); end
    clear_cu = 1'b0;
    line(1'b1, 100);
    checks++; if (n_fe != fe0) begin failures++; $display("FAIL ab_clr_frame_end got=%0d exp=0", n_fe - fe0); end
    head(24, 24, 66, 150);
    sym(40);
    line(1'b1, 10);
    rx_en = 1'b0;
    line(1'b1, 2);
    checks++; if (bit_cnt !== 8'd0) begin failures++; $display("FAIL ab_en_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (tari !== 10'd0) begin failures++; $display("FAIL ab_en_tari got=%0d exp=0", tari); end
    rx_en = 1'b1;
    line(1'b1, 100);
    checks++; if (n_fe != fe0) begin failures++; $display("FAIL ab_en_frame_end got=%0d exp=0", n_fe - fe0); end
    checks++; if (n_err != e0) begin failures++; $display("FAIL ab_err got=%0d exp=0", n_err - e0); end
    fe0 = n_fe; b0 = n_bits;
    head(24, 24, 66, 0);
    sym(24); sym(40);
    line(1'b1, 100);
    checks++; if (n_bits - b0 != 2) begin failures++; $display("FAIL ab_next_nbits got=%0d exp=2", n_bits - b0); end
    checks++; if (bits[b0] !== 1'b0 || bits[b0+1] !== 1'b1) begin failures++; $display("FAIL ab_next_bits got=%0b%0b exp=01", bits[b0], bits[b0+1]); end
    checks++; if (n_fe - fe0 != 1) begin failures++; $display("FAIL ab_next_end got=%0d exp=1", n_fe - fe0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_query;
    test_non_query;
    test_pivot;
    test_framing_err;
    test_stuck_low;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
